first_sweep_ctrl: RTL
=====================

// Module: first_sweep_ctrl
// PURPOSE
//  Sequencer for the 3-input/2-output combinational block `first` (inputs a,b,c; outputs f1,f2).
//  On start, drives all 8 {a,b,c} combinations in ascending order, holding each for HOLD_CYCLES.
//  Samples {f1,f2} on the last hold cycle of each combination and checks it against truth tables.
//  Sits between a test/config master and the `first` instance; replaces hand-written input sweeps.
// PARAMETERS
//  HOLD_CYCLES  20     cycles each combination is held; legal >= 1
//  EXP_F1       8'h00  expected f1 truth table; bit i = f1 for {a,b,c}==i
//  EXP_F2       8'h00  expected f2 truth table; bit i = f2 for {a,b,c}==i
//  CHECK_EN     1      1: compare against EXP_*; 0: mismatch/err held at 0
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   begin sweep; sampled only in IDLE
//  abort     in   1   stop sweep immediately; wins over all other events
//  f1        in   1   observed output of `first`
//  f2        in   1   observed output of `first`
//  a         out  1   drive to `first`; MSB of combination index
//  b         out  1   drive to `first`
//  c         out  1   drive to `first`; LSB of combination index
//  busy      out  1   high in SETTLE
//  done      out  1   one-cycle pulse on sweep completion
//  results   out  16  captured {f1,f2} for index i at bits [2i+1:2i]
//  mismatch  out  8   bit i set when sample i differs from {EXP_F1[i],EXP_F2[i]}
//  err       out  1   registered OR of mismatch
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; a,b,c,busy,done,err=0; results=16'h0; mismatch=8'h0.
//  States: IDLE -> SETTLE -> DONE -> IDLE.
//  IDLE: start=1 -> clear results and mismatch; idx=0; cnt=HOLD_CYCLES-1; go to SETTLE.
//  SETTLE: {a,b,c}=idx (registered); busy=1; cnt decrements every cycle.
//    cnt==0: capture results[2*idx+:2]<={f1,f2}; set mismatch[idx] on miscompare.
//      idx==7: go to DONE. Otherwise idx++, cnt reloads to HOLD_CYCLES-1.
//  DONE: done=1 for exactly one cycle; a,b,c return to 0; go to IDLE.
//  Latency: each index is driven for exactly HOLD_CYCLES cycles.
//    done is high in the cycle starting 8*HOLD_CYCLES+1 edges after the start edge.
//  start while busy or in DONE: ignored; no restart and no clear.
//  abort=1, any state: next edge -> IDLE; a,b,c=0; done not pulsed.
//    results and mismatch keep partial contents.
//  abort and start together in IDLE: abort wins; stay in IDLE; no clear.
//  err updates one cycle after mismatch; results/mismatch/err hold until the next accepted start.
//  Widths: idx 3 bits (no wrap; terminates at 7); cnt is $clog2(HOLD_CYCLES+1) bits.
//  HOLD_CYCLES=1: each index is held 1 cycle and sampled in that cycle.
// STRUCTURE
//  Shared header first_sweep_defs.vh holds N_COMBOS=8, IDX_W=3 and the state encodings
//  S_IDLE/S_SETTLE/S_DONE.
//  One sub-module, first_hold_timer: loadable down-counter with zero flag, parameterised by HOLD_CYCLES.
//  FSM, index register, capture and compare logic stay in first_sweep_ctrl.
// TESTING (bench: first_sweep_ctrl_tb; real `first` instance, plus a behavioural model for fault cases)
//  1. Reset mid-sweep (rst_n low at idx=3) -> all outputs 0 immediately, before any clock edge.
//  2. HOLD_CYCLES=20, EXP_* = golden tables of `first`, pulse start
//     -> {a,b,c} steps 000..111, 20 cycles each; done at cycle 161; mismatch=8'h00; err=0.
//  3. Model forces f1 stuck-at-1, EXP_F1=8'h00 -> mismatch=8'hFF; err=1 one cycle later;
//     results odd bits all 1.
//  4. abort at idx=4, mid-hold -> IDLE next edge; no done; results[7:0] valid;
//     results[15:8]=0; busy=0.
//  5. start re-pulsed at idx=2 -> ignored; sweep completes normally.
//     New start after done -> results/mismatch cleared on that edge.
//  6. HOLD_CYCLES=1 -> 8 consecutive distinct {a,b,c} values; done at cycle 9;
//     start+abort in the same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/first_sweep_ctrl_pkg.sv
// Shared constants for the `first` input sweeper: combination count, index width, FSM encodings.
// No logic; no latency.
// No flow control.
package first_sweep_ctrl_pkg;

  localparam int N_COMBOS = 8;
  localparam int IDX_W    = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

endpackage

// File: rtl/first_sweep_ctrl_hold_timer.sv
// Loadable down-counter that measures how long one {a,b,c} combination is held.
// zero is combinational from the count; a load takes effect on the next edge.
// No flow control; counts whenever enabled and parks at zero.
module first_hold_timer #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HOLD_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/first_sweep_ctrl.sv
// Sweeps {a,b,c} through all 8 combinations for `first`, sampling and checking {f1,f2} per index.
// Each index is held HOLD_CYCLES cycles; done pulses 8*HOLD_CYCLES+1 edges after the start edge.
// start is ignored outside IDLE; abort returns to IDLE on the next edge and wins over start.
module first_sweep_ctrl
  import first_sweep_ctrl_pkg::*;
#(
  parameter int         HOLD_CYCLES = 20,
  parameter logic [7:0] EXP_F1      = 8'h00,
  parameter logic [7:0] EXP_F2      = 8'h00,
  parameter bit         CHECK_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f1,
  input  logic        f2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        busy,
  output logic        done,
  output logic [15:0] results,
  output logic [7:0]  mismatch,
  output logic        err
);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] drv;
  logic             tmr_load;
  logic             tmr_zero;

  // Reload on an accepted start and at every index boundary; abort leaves the timer alone
  // because the next accepted start reloads it anyway.
  assign tmr_load = ((state == S_IDLE) && start && !abort) ||
                    ((state == S_SETTLE) && tmr_zero);

  first_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (state == S_SETTLE),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      drv      <= '0;
      done     <= 1'b0;
      results  <= 16'h0;
      mismatch <= 8'h0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= |mismatch;
      if (abort) begin
        state <= S_IDLE;
        drv   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_SETTLE;
              idx      <= '0;
              drv      <= '0;
              results  <= 16'h0;
              mismatch <= 8'h0;
            end
          end
          S_SETTLE: begin
            if (tmr_zero) begin
              results[{idx, 1'b0} +: 2] <= {f1, f2};
              mismatch[idx] <= CHECK_EN && ({f1, f2} != {EXP_F1[idx], EXP_F2[idx]});
              if (idx == IDX_W'(N_COMBOS - 1)) begin
                state <= S_DONE;
                drv   <= '0;
              end else begin
                idx <= idx + 1'b1;
                drv <= idx + 1'b1;
              end
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign {a, b, c} = drv;
  assign busy      = (state == S_SETTLE);

endmodule
